fpa_normalize_pack: RTL and testbench

Back-end stage of the pipelined floating-point adder. It accepts the raw 32-bit mantissa sum, the pre-alignment exponent and the result sign from the align/add stage. It normalizes the sum (1-bit right shift on carry-out, leading-zero left shift otherwise), adjusts the exponent, applies overflow, underflow and zero rules, and packs an IEEE-754 single-precision word. It is a 3-stage valid/ready pipeline sustaining one result per cycle.

---
 rtl/fpa_normalize_pack.sv | 182 ++++++++++++++++++
 tb/tb_fpa_normalize_pack.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpa_normalize_pack.sv
// Purpose: FP adder back end; normalizes the raw mantissa sum, applies exponent
//          exception rules and packs an IEEE-754 single-precision word.
// Latency: 3 stages; a beat captured at edge N is consumed downstream at edge N+3.
// Backpressure: valid/ready; a stage loads when empty or when the next stage loads.
//          in_ready is the only combinational output.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_sign             result sign from the add stage
//   in_exp[7:0]         larger operand's biased exponent (pre-normalization)
//   in_man[31:0]        adder sum. The carry sits at bit 24 and the hidden 1 at
//                       bit 23, so a 1.0+1.0 sum (32'h0100_0000) takes the carry
//                       path. Bits 31:25 are ignored.
//   out_valid/out_ready downstream handshake
//   out_result[31:0]    {sign, exp[7:0], frac[22:0]}
//   out_flags[2:0]      {overflow, underflow, zero}. This port exists only when
//                       FPA_FLAGS_EN is defined.
module fpa_normalize_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [31:0] in_man,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
`ifdef FPA_FLAGS_EN
    ,
    output logic [2:0]  out_flags
`endif
);

    // Pipeline advance chain. A stage loads when it is empty or when its
    // successor loads in the same cycle. A full pipe can therefore accept a
    // beat and drain one in the same cycle.
    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;

    // The bits above the carry carry no information.
    logic unused_man_hi;
    assign unused_man_hi = ^in_man[31:25];

    // ---------------- stage 1: capture ----------------
    logic        s1_sign, s1_zero, s1_inf;
    logic [7:0]  s1_exp;
    logic [24:0] s1_man;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_inf  <= 1'b0;
            s1_exp  <= 8'h00;
            s1_man  <= 25'h0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_exp  <= in_exp;
                s1_man  <= in_man[24:0];
                s1_zero <= (in_man[24:0] == 25'h0);
                s1_inf  <= (in_exp == 8'hFF);
            end
        end
    end

    // ---------------- stage 2: normalize ----------------
    logic              carry;
    logic [4:0]        lz;
    logic              lz_found;
    logic [22:0]       shifted;
    logic [22:0]       norm_frac;
    logic signed [9:0] norm_exp;

    assign carry = s1_man[24];

    // Leading-zero count over the 24 bits below the carry. An all-zero field is
    // flagged as is_zero and never reaches the pack, so lz stays within 0..23.
    always_comb begin
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found && s1_man[i]) begin
                lz       = 5'(23 - i);
                lz_found = 1'b1;
            end
        end
    end

    // Only the bits below the hidden 1 matter after the shift.
    assign shifted   = s1_man[22:0] << lz;
    assign norm_frac = carry ? s1_man[23:1] : shifted;
    // The exponent uses 10 signed bits so that 255+1 and 0-23 are both exact.
    assign norm_exp  = carry ? ($signed({2'b00, s1_exp}) + 10'sd1)
                             : ($signed({2'b00, s1_exp}) - $signed({5'b00000, lz}));

    logic              s2_sign, s2_zero, s2_inf;
    logic signed [9:0] s2_exp;
    logic [22:0]       s2_frac;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2      <= 1'b0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_inf  <= 1'b0;
            s2_exp  <= 10'sd0;
            s2_frac <= 23'h0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s2_sign <= s1_sign;
                s2_zero <= s1_zero;
                s2_inf  <= s1_inf;
                s2_exp  <= norm_exp;
                s2_frac <= norm_frac;
            end
        end
    end

    // ---------------- stage 3: pack and exceptions ----------------
    logic [31:0] pk_result;

    always_comb begin
        pk_result = {s2_sign, s2_exp[7:0], s2_frac};
        if (s2_inf)
            pk_result = {s2_sign, 8'hFF, 23'h0};
        else if (s2_zero)
            pk_result = 32'h0000_0000;
        else if (s2_exp >= 10'sd255)
            pk_result = {s2_sign, 8'hFF, 23'h0};
        else if (s2_exp <= 10'sd0)
            pk_result = {s2_sign, 31'h0};   // denormals flush, sign kept
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v3         <= 1'b0;
            out_result <= 32'h0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2)
                out_result <= pk_result;
        end
    end

`ifdef FPA_FLAGS_EN
    // The flags follow the same priority as the pack. An infinity input is
    // passed through and does not count as an overflow.
    logic [2:0] pk_flags;

    always_comb begin
        pk_flags = 3'b000;
        if (s2_inf)
            pk_flags = 3'b000;
        else if (s2_zero)
            pk_flags = 3'b001;
        else if (s2_exp >= 10'sd255)
            pk_flags = 3'b100;
        else if (s2_exp <= 10'sd0)
            pk_flags = 3'b010;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_flags <= 3'b000;
        else if (adv3 && v2)
            out_flags <= pk_flags;
    end
`endif

endmodule

// File: tb/tb_fpa_normalize_pack.sv
// Purpose: self-checking bench for fpa_normalize_pack. It uses directed vectors,
//          a 6-beat stall, random streams and a reset in mid-flight.
// Latency: expects a beat accepted at edge N to be consumed at edge N+3 when
//          out_ready stays high.
// Backpressure: out_ready is held low over a window and then toggled at random.
//          FPA_FLAGS_EN selects whether the flags are also compared.
module tb_fpa_normalize_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [31:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
`ifdef FPA_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    fpa_normalize_pack dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_man     (in_man),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef FPA_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Reference model computed on the numeric value of the sum. Bit 24 is the
    // carry and bit 23 is the hidden 1. The model returns {ovf, unf, zero, word}.
    function automatic logic [34:0] model(input logic s, input logic [7:0] e, input logic [31:0] man);
        int          m;
        int          ex;
        logic [22:0] frac;
        logic [31:0] r;
        logic        ov, un, z;
        m  = int'(man & 32'h01FF_FFFF);
        ex = int'(e);
        ov = 1'b0; un = 1'b0; z = 1'b0;
        if (e == 8'hFF) begin
            r = {s, 8'hFF, 23'h0};
        end else if (m == 0) begin
            r = 32'h0;
            z = 1'b1;
        end else begin
            if (m >= (1 << 24)) begin
                m  = m >> 1;            // truncate, no rounding
                ex = ex + 1;
            end
            while (m < (1 << 23)) begin
                m  = m << 1;
                ex = ex - 1;
            end
            frac = 23'(m);
            if (ex >= 255) begin
                r  = {s, 8'hFF, 23'h0};
                ov = 1'b1;
            end else if (ex <= 0) begin
                r  = {s, 31'h0};
                un = 1'b1;
            end else begin
                r = {s, 8'(ex), frac};
            end
        end
        return {ov, un, z, r};
    endfunction

    // Scoreboard
    logic [34:0] exp_q[$];
    int          cyc_q[$];
    bit          lc_q[$];
    int          cyc = 0;
    int          n_in = 0;
    int          n_out = 0;
    bit          lat_chk = 1'b0;
    bit          dir_vld = 1'b0;
    logic [31:0] dir_res;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_res;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            // Fewer than 3 beats held means some stage is empty and can load.
            check("in_ready", {31'h0, in_ready},
                  {31'h0, (exp_q.size() < 3) || out_ready});
            if (prev_stall) begin
                check("hold_valid", {31'h0, out_valid}, 32'h1);
                check("hold_result", out_result, prev_res);
            end
            if (out_valid && exp_q.size() == 0) begin
                check("spurious_valid", {31'h0, out_valid}, 32'h0);
            end else if (out_valid && out_ready) begin
                logic [34:0] e;
                int          c;
                bit          l;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                l = lc_q.pop_front();
                check("result", out_result, e[31:0]);
`ifdef FPA_FLAGS_EN
                check("flags", {29'h0, out_flags}, {29'h0, e[34:32]});
`endif
                if (l) check("latency", cyc - c, 32'd3);
                n_out++;
            end
            if (in_valid && in_ready) begin
                logic [34:0] e;
                e = model(in_sign, in_exp, in_man);
                if (dir_vld) e[31:0] = dir_res;
                exp_q.push_back(e);
                cyc_q.push_back(cyc);
                lc_q.push_back(lat_chk);
                n_in++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
        end
    end

    // Present one beat and hold it until it is accepted. The wait is bounded.
    task automatic send(input logic s, input logic [7:0] e, input logic [31:0] m);
        int budget;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_man   = m;
        budget   = 200;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget--;
            if (budget == 0) begin
                check("accept_timeout", {31'h0, in_ready}, 32'h1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dir_vld  = 1'b0;
    endtask

    task automatic send_dir(input logic s, input logic [7:0] e, input logic [31:0] m,
                            input logic [31:0] want);
        dir_vld = 1'b1;
        dir_res = want;
        send(s, e, m);
    endtask

    task automatic send_rand();
        logic [7:0]  e;
        logic [31:0] m;
        case ($urandom_range(0, 3))
            0:       e = 8'($urandom_range(0, 24));
            1:       e = 8'($urandom_range(230, 255));
            default: e = 8'($urandom);
        endcase
        m = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
        send(1'($urandom), e, m);
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("drain_left", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    bit rand_done;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'h0;
        in_man    = 32'h0;
        out_ready = 1'b1;
        #22;
        reset = 1'b0;
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_result", out_result, 32'h0);
`ifdef FPA_FLAGS_EN
        check("rst_out_flags", {29'h0, out_flags}, 32'h0);
`endif
        @(posedge clk);
        #1;

        // Directed vectors, back to back at full rate
        lat_chk = 1'b1;
        send_dir(1'b0, 8'd127, 32'h0100_0000, 32'h4000_0000);
        send_dir(1'b0, 8'd127, 32'h0040_0000, 32'h3F00_0000);
        send_dir(1'b0, 8'd127, 32'h0000_0001, 32'h3400_0000);
        send_dir(1'b0, 8'd254, 32'h0100_0000, 32'h7F80_0000);
        send_dir(1'b1, 8'd1,   32'h0040_0000, 32'h8000_0000);
        send_dir(1'b1, 8'd100, 32'h0000_0000, 32'h0000_0000);
        send_dir(1'b1, 8'hFF,  32'h0080_0000, 32'hFF80_0000);
        send_dir(1'b0, 8'd127, 32'hFE80_0000, 32'h3F80_0000);
        drain();

        // Six beats, with out_ready low for cycles 2-6
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(1'b0, 8'(120 + i), 32'h0080_0000 + 32'(i << 18));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Streaming at full rate with the latency checked
        lat_chk = 1'b1;
        for (int i = 0; i < 100; i++) send_rand();
        drain();

        // Random back-pressure
        lat_chk   = 1'b0;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) send_rand();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset asserted with two beats in flight
        lat_chk = 1'b1;
        send(1'b0, 8'd127, 32'h0100_0000);
        send(1'b0, 8'd127, 32'h0080_0000);
        @(posedge clk);
        #1;
        check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_result", out_result, 32'h0);
        n_in -= exp_q.size();
        exp_q.delete();
        cyc_q.delete();
        lc_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (6) @(posedge clk);
        #1;
        send_dir(1'b1, 8'd130, 32'h00C0_0000, 32'hC140_0000);
        drain();

        check("beat_count", n_out, n_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
